// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / taken-branch / freeze sequencing for the five-stage pipeline.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] AselID,
  input  logic [31:0] BselID,
  input  logic        BusedID,
  input  logic [31:0] DselEX,
  input  logic        LoadEX,
  input  logic        branch_taken,
  input  logic        freeze,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    FLUSH
  } state_e;

  localparam logic [2:0] LD_REM = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FL_REM = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] remain_q, remain_d;
  logic [30:0] src_sel;
  logic        haz;

  // XZR (bit 31) is never a real dependency
  assign src_sel = AselID[30:0] | (BusedID ? BselID[30:0] : 31'd0);
  assign haz     = LoadEX & (|(DselEX[30:0] & src_sel));

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      state_d  = RUN;
      remain_d = 3'd0;
    end else if (freeze) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d  = FLUSH;
        remain_d = FL_REM;
      end else begin
        state_d  = RUN;
        remain_d = 3'd0;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (haz) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            if (LD_REM != 3'd0) begin
              state_d  = LDSTALL;
              remain_d = LD_REM;
            end
          end
        end
        LDSTALL: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          remain_d    = remain_q - 3'd1;
          if (remain_q == 3'd1) state_d = RUN;
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          remain_d   = remain_q - 3'd1;
          if (remain_q == 3'd1) state_d = RUN;
        end
        default: begin
          state_d  = RUN;
          remain_d = 3'd0;
        end
      endcase
    end
  end

  assign busy = ~reset & (state_q != RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      remain_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        ld_stall;

  // pc_hold outside freeze can only come from a load-use stall
  assign ld_stall = pc_hold & ~freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ld_stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_flush && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: three parameterisations share stimulus,
// a cycle-count reference model predicts every output.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int LP[3] = '{1, 3, 2};
  localparam int FP[3] = '{2, 3, 1};

  typedef struct {
    int          ps;
    int          pf;
    logic [31:0] sc;
    logic [31:0] fc;
    bit          known;
  } mdl_t;

  typedef struct {
    logic        ph, ih, fl, bb, bz;
    logic [31:0] sc, fc;
    bit          cc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] asel = '0, bsel = '0, dsel = '0;
  logic        bused = 1'b0, load = 1'b0;
  logic        br = 1'b0, frz = 1'b0;

  logic [2:0]       ph, ih, fl, bb, bz;
  logic [2:0][31:0] sc, fc;

  pipeline_hazard_ctrl u_a (
    .clk(clk), .reset(reset),
    .AselID(asel), .BselID(bsel), .BusedID(bused),
    .DselEX(dsel), .LoadEX(load),
    .branch_taken(br), .freeze(frz),
    .pc_hold(ph[0]), .ifid_hold(ih[0]),
    .ifid_flush(fl[0]), .idex_bubble(bb[0]),
    .busy(bz[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0])
  );

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3)
  ) u_b (
    .clk(clk), .reset(reset),
    .AselID(asel), .BselID(bsel), .BusedID(bused),
    .DselEX(dsel), .LoadEX(load),
    .branch_taken(br), .freeze(frz),
    .pc_hold(ph[1]), .ifid_hold(ih[1]),
    .ifid_flush(fl[1]), .idex_bubble(bb[1]),
    .busy(bz[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1])
  );

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(1)
  ) u_c (
    .clk(clk), .reset(reset),
    .AselID(asel), .BselID(bsel), .BusedID(bused),
    .DselEX(dsel), .LoadEX(load),
    .branch_taken(br), .freeze(frz),
    .pc_hold(ph[2]), .ifid_hold(ih[2]),
    .ifid_flush(fl[2]), .idex_bubble(bb[2]),
    .busy(bz[2]), .stall_cnt(sc[2]), .flush_cnt(fc[2])
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[3][$];
  mdl_t m[3];
  exp_t e;

  function automatic void chk(input int k, input string nm,
                              input logic [31:0] act,
                              input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s u%0d t=%0t got %0h want %0h",
               nm, k, $time, act, want);
    end
  endfunction

  // Counts owed stall / flush cycles rather than tracking states.
  function automatic void step(input mdl_t cur, input int l, input int f,
                               input bit r, input bit fz, input bit b,
                               input bit hz, output exp_t x,
                               output mdl_t nx);
    bit stall;
    nx    = cur;
    x     = '{default: '0};
    x.cc  = cur.known;
    x.sc  = PERF ? cur.sc : 32'd0;
    x.fc  = PERF ? cur.fc : 32'd0;
    stall = 1'b0;
    if (r) begin
      nx = '{ps: 0, pf: 0, sc: 32'd0, fc: 32'd0, known: 1'b1};
      return;
    end
    x.bz = (cur.ps > 0) || (cur.pf > 0);
    if (fz) begin
      x.ph = 1'b1;
      x.ih = 1'b1;
      return;
    end
    if (b) begin
      x.fl  = 1'b1;
      x.bb  = 1'b1;
      nx.ps = 0;
      nx.pf = f - 1;
    end else if (cur.pf > 0) begin
      x.fl  = 1'b1;
      nx.pf = cur.pf - 1;
    end else if (cur.ps > 0) begin
      stall = 1'b1;
      nx.ps = cur.ps - 1;
    end else if (hz) begin
      stall = 1'b1;
      nx.ps = l - 1;
    end
    if (stall) begin
      x.ph = 1'b1;
      x.ih = 1'b1;
      x.bb = 1'b1;
      if (cur.sc != 32'hFFFF_FFFF) nx.sc = cur.sc + 32'd1;
    end
    if (x.fl && cur.fc != 32'hFFFF_FFFF) nx.fc = cur.fc + 32'd1;
  endfunction

  task automatic drive(input bit r, input bit fz, input bit b,
                       input bit ld, input int di, input int ai,
                       input int bi, input bit bu);
    exp_t x;
    mdl_t nx;
    bit   hz;
    @(posedge clk);
    #1;
    reset = r;
    frz   = fz;
    br    = b;
    load  = ld;
    bused = bu;
    dsel  = 32'd1 << di;
    asel  = 32'd1 << ai;
    bsel  = 32'd1 << bi;
    hz = ld && (di != 31) && (ai == di || (bu && bi == di));
    for (int k = 0; k < 3; k++) begin
      step(m[k], LP[k], FP[k], r, fz, b, hz, x, nx);
      m[k] = nx;
      q[k].push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 1, 2, 0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (q[k].size() > 0) begin
        e = q[k].pop_front();
        chk(k, "pc_hold", 32'(ph[k]), 32'(e.ph));
        chk(k, "ifid_hold", 32'(ih[k]), 32'(e.ih));
        chk(k, "ifid_flush", 32'(fl[k]), 32'(e.fl));
        chk(k, "idex_bubble", 32'(bb[k]), 32'(e.bb));
        chk(k, "busy", 32'(bz[k]), 32'(e.bz));
        chk(k, "hold_flush_excl", 32'(ih[k] & fl[k]), 32'd0);
        if (e.cc) begin
          chk(k, "stall_cnt", sc[k], e.sc);
          chk(k, "flush_cnt", fc[k], e.fc);
        end
      end
    end
  end

  initial begin
    bit r, fz, b, ld, bu;
    int di, ai, bi;
    for (int k = 0; k < 3; k++)
      m[k] = '{ps: 0, pf: 0, sc: 32'd0, fc: 32'd0, known: 1'b0};
    drive(1, 0, 1, 1, 3, 3, 0, 0);
    drive(1, 0, 1, 1, 3, 3, 0, 0);
    drive(0, 0, 0, 1, 3, 3, 0, 0);
    idle(4);
    drive(0, 0, 0, 1, 31, 31, 0, 0);
    drive(0, 0, 0, 1, 5, 0, 5, 0);
    idle(1);
    drive(0, 0, 0, 1, 5, 0, 5, 1);
    idle(4);
    drive(0, 0, 0, 1, 7, 7, 0, 0);
    drive(0, 0, 1, 1, 7, 7, 0, 0);
    idle(4);
    drive(0, 0, 1, 0, 0, 1, 2, 0);
    repeat (3) drive(0, 1, 1, 0, 0, 1, 2, 0);
    idle(4);
    drive(0, 0, 0, 1, 9, 9, 0, 0);
    drive(0, 0, 0, 1, 9, 9, 0, 0);
    drive(0, 0, 0, 1, 9, 9, 0, 0);
    drive(0, 0, 0, 1, 9, 9, 0, 0);
    idle(4);
    drive(0, 0, 1, 0, 0, 1, 2, 0);
    drive(0, 0, 0, 1, 4, 4, 0, 0);
    drive(0, 0, 1, 0, 0, 1, 2, 0);
    idle(5);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom % 100) < 2;
      fz = ($urandom % 100) < 10;
      b  = ($urandom % 100) < 15;
      ld = ($urandom % 100) < 60;
      bu = $urandom % 2;
      di = $urandom % 32;
      ai = ($urandom % 2) ? di : int'($urandom % 32);
      bi = ($urandom % 2) ? di : int'($urandom % 32);
      drive(r, fz, b, ld, di, ai, bi, bu);
    end
    idle(3);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk(k, "scoreboard_drained", 32'(q[k].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
